// File: rtl/fp_sum_reduce_pkg.sv
// Shared floating-point parameters and the reduction FSM encoding.
package fp_sum_reduce_pkg;

  localparam int FP_FRAC_WIDTH  = 24;
  localparam int FP_EXP_WIDTH   = 8;
  localparam int FP_ADD_LATENCY = 13;

  localparam logic [FP_FRAC_WIDTH+FP_EXP_WIDTH-1:0] FP_POS_ZERO = '0;
  localparam logic [FP_FRAC_WIDTH+FP_EXP_WIDTH-1:0] FP_QNAN =
    {1'b0, {FP_EXP_WIDTH{1'b1}}, 1'b1, {(FP_FRAC_WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/fp_sum_reduce_add.sv
// Pipelined IEEE-754 adder: round-to-nearest-even, subnormals flushed to zero,
// result delayed LATENCY cycles. Only the valid pipeline is reset.
module floating_point_add
  import fp_sum_reduce_pkg::*;
#(
  parameter int FRAC_WIDTH = FP_FRAC_WIDTH,
  parameter int EXP_WIDTH  = FP_EXP_WIDTH,
  parameter int LATENCY    = FP_ADD_LATENCY
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            valid_i,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] a_i,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] b_i,
  output logic                            valid_o,
  output logic [FRAC_WIDTH+EXP_WIDTH-1:0] sum_o
);
  localparam int DW = FRAC_WIDTH + EXP_WIDTH;
  localparam int MW = FRAC_WIDTH - 1;
  localparam int N  = FRAC_WIDTH + 3;
  localparam int XW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [EXP_WIDTH-1:0] SH_MAX  = EXP_WIDTH'(N);
  localparam logic [DW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic                 a_s, b_s, x_s, y_s;
  logic [EXP_WIDTH-1:0] a_e, b_e, x_e, y_e, shamt;
  logic [MW-1:0]        a_m, b_m, x_m, y_m;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [N-1:0]         mx, my, my_al, lost, norm;
  logic [N:0]           sum_raw;
  logic [XW-1:0]        lz, exp_r;
  logic                 found, rnd;
  logic [FRAC_WIDTH:0]  mant_r;
  logic [DW-1:0]        res;

  logic [LATENCY-1:0]   vld_q;
  logic [DW-1:0]        pipe_q [LATENCY];

  assign {a_s, a_e, a_m} = a_i;
  assign {b_s, b_e, b_m} = b_i;
  assign a_nan  = (a_e == EXP_MAX) && (a_m != '0);
  assign b_nan  = (b_e == EXP_MAX) && (b_m != '0);
  assign a_inf  = (a_e == EXP_MAX) && (a_m == '0);
  assign b_inf  = (b_e == EXP_MAX) && (b_m == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign swap   = {b_e, b_m} > {a_e, a_m};

  always_comb begin
    x_s = swap ? b_s : a_s;
    x_e = swap ? b_e : a_e;
    x_m = swap ? b_m : a_m;
    y_s = swap ? a_s : b_s;
    y_e = swap ? a_e : b_e;
    y_m = swap ? a_m : b_m;
    mx    = {1'b1, x_m, 3'b000};
    my    = {1'b1, y_m, 3'b000};
    shamt = x_e - y_e;
    lost  = '0;
    // The smaller operand keeps guard/round bits and a sticky bit of what falls off.
    if (shamt >= SH_MAX) begin
      my_al = {{(N-1){1'b0}}, 1'b1};
    end else begin
      my_al    = my >> shamt;
      lost     = my & ~({N{1'b1}} << shamt);
      my_al[0] = my_al[0] | (|lost);
    end
    sum_raw = (x_s != y_s) ? ({1'b0, mx} - {1'b0, my_al}) : ({1'b0, mx} + {1'b0, my_al});
    lz    = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_raw[i]) found = 1'b1;
        else            lz    = lz + XW'(1);
      end
    end
    if (sum_raw[N]) begin
      norm    = sum_raw[N:1];
      norm[0] = norm[0] | sum_raw[0];
      exp_r   = {2'b00, x_e} + XW'(1);
    end else begin
      norm  = sum_raw[N-1:0] << lz;
      exp_r = {2'b00, x_e} - lz;
    end
    rnd    = norm[2] & ((|norm[1:0]) | norm[3]);
    mant_r = {1'b0, norm[N-1:3]} + {{FRAC_WIDTH{1'b0}}, rnd};
    if (mant_r[FRAC_WIDTH]) begin
      mant_r = mant_r >> 1;
      exp_r  = exp_r + XW'(1);
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) res = QNAN;
    else if (a_inf)                                      res = a_i;
    else if (b_inf)                                      res = b_i;
    else if (a_zero && b_zero)                           res = {a_s & b_s, {(DW-1){1'b0}}};
    else if (a_zero)                                     res = b_i;
    else if (b_zero)                                     res = a_i;
    else if (sum_raw == '0)                              res = '0;
    else if (exp_r[XW-1] || (exp_r == '0))               res = {x_s, {(DW-1){1'b0}}};
    else if (exp_r >= {2'b00, EXP_MAX})                  res = {x_s, EXP_MAX, {MW{1'b0}}};
    else                                                 res = {x_s, exp_r[EXP_WIDTH-1:0], mant_r[MW-1:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
      vld_q[0] <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = LATENCY - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
    pipe_q[0] <= res;
  end

  assign valid_o = vld_q[LATENCY-1];
  assign sum_o   = pipe_q[LATENCY-1];

endmodule

// File: rtl/fp_sum_reduce.sv
// Streaming floating-point sum: elements and adder results share one operand queue,
// and any two queued values are added until a single value remains.
module fp_sum_reduce
  import fp_sum_reduce_pkg::*;
#(
  parameter int FRAC_WIDTH  = FP_FRAC_WIDTH,
  parameter int EXP_WIDTH   = FP_EXP_WIDTH,
  parameter int LEN_WIDTH   = 16,
  parameter int QUEUE_DEPTH = 16,
  parameter int ADD_LATENCY = FP_ADD_LATENCY
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic                            startIn,
  input  logic [LEN_WIDTH-1:0]            lenIn,
  input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataIn,
  input  logic                            validIn,
  output logic                            readyOut,
  output logic [FRAC_WIDTH+EXP_WIDTH-1:0] sumOut,
  output logic                            doneOut,
  output logic                            busyOut
);
  localparam int DW = FRAC_WIDTH + EXP_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int IW = $clog2(ADD_LATENCY + 1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] term_q, term_d, recv_q, recv_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        infl_q, infl_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [DW-1:0]        sum_q, sum_d;
  logic                 done_q, done_d, ready_q, ready_d, busy_q, busy_d;
  logic [DW-1:0]        mem_q [QUEUE_DEPTH];

  logic                 accept, add_valid, add_valid_o;
  logic [DW-1:0]        add_sum_o;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(QUEUE_DEPTH)) s = s - (PW+1)'(QUEUE_DEPTH);
    return s[PW-1:0];
  endfunction

  assign accept    = validIn && ready_q;
  assign add_valid = (state_q == ST_ACCUM) && (cnt_q >= CW'(2));
  assign head_p1   = ptr_add(head_q, 2'd1);
  assign tail_p1   = ptr_add(tail_q, 2'd1);

  floating_point_add #(
    .FRAC_WIDTH (FRAC_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .LATENCY    (ADD_LATENCY)
  ) u_add (
    .clk_i   (clkIn),
    .rst_i   (~rstIn),
    .valid_i (add_valid),
    .a_i     (mem_q[head_q]),
    .b_i     (mem_q[head_p1]),
    .valid_o (add_valid_o),
    .sum_o   (add_sum_o)
  );

  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    recv_d  = recv_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    head_d  = add_valid ? ptr_add(head_q, 2'd2) : head_q;
    tail_d  = ptr_add(tail_q, {1'b0, add_valid_o} + {1'b0, accept});
    cnt_d   = cnt_q + CW'(add_valid_o) + CW'(accept) - (add_valid ? CW'(2) : CW'(0));
    infl_d  = infl_q + IW'(add_valid) - IW'(add_valid_o);
    unique case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          state_d = ST_ACCUM;
          term_d  = lenIn;
          recv_d  = lenIn;
        end
      end
      ST_ACCUM: begin
        if (accept)    recv_d = recv_q - LEN_WIDTH'(1);
        if (add_valid) term_d = term_q - LEN_WIDTH'(1);
        // A zero-length run has nothing to reduce and finishes immediately.
        if ((term_q == '0) ||
            ((term_q == LEN_WIDTH'(1)) && (infl_q == '0) && (cnt_q == CW'(1)) && (recv_q == '0)))
          state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        sum_d   = (term_q == '0) ? '0 : mem_q[head_q];
        term_d  = '0;
        cnt_d   = '0;
        head_d  = '0;
        tail_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_ACCUM) && (recv_d != '0) &&
              (({1'b0, cnt_d} + (CW+1)'(infl_d)) <= (CW+1)'(QUEUE_DEPTH - 2));
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q <= ST_IDLE;
      term_q  <= '0;
      recv_q  <= '0;
      cnt_q   <= '0;
      infl_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      recv_q  <= recv_d;
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // A returning adder result is queued ahead of an element accepted in the same cycle.
  always_ff @(posedge clkIn) begin
    if (add_valid_o) mem_q[tail_q] <= add_sum_o;
    if (accept)      mem_q[add_valid_o ? tail_p1 : tail_q] <= dataIn;
  end

  assign readyOut = ready_q;
  assign sumOut   = sum_q;
  assign doneOut  = done_q;
  assign busyOut  = busy_q;

endmodule

// File: tb/tb_fp_sum_reduce.sv
// Randomized and directed bench for fp_sum_reduce; expected sums come from integer
// arithmetic converted to IEEE-754, so any reduction order must give the same bits.
module tb_fp_sum_reduce;
  localparam int FW = 24;
  localparam int EW = 8;
  localparam int LW = 16;
  localparam int QD = 16;
  localparam int AL = 13;
  localparam int DW = FW + EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len_i;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] sum;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  fp_sum_reduce #(
    .FRAC_WIDTH (FW), .EXP_WIDTH (EW), .LEN_WIDTH (LW),
    .QUEUE_DEPTH(QD), .ADD_LATENCY(AL)
  ) dut (
    .clkIn   (clk),
    .rstIn   (rst_n),
    .startIn (start),
    .lenIn   (len_i),
    .dataIn  (data),
    .validIn (valid),
    .readyOut(ready),
    .sumOut  (sum),
    .doneOut (done),
    .busyOut (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_adds   = 0;
  int q_over   = 0;

  logic [DW-1:0] elem_q[$];
  logic [DW-1:0] exp_q[$];

  int done_cnt, done_cyc, ready_hi, throttled, overrun;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] int2fp(input int v);
    int mag, e, frac;
    logic [EW-1:0] ex;
    if (v == 0) return '0;
    mag = (v < 0) ? -v : v;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    frac = mag << (23 - e);
    ex = EW'(127 + e);
    return {(v < 0), ex, frac[22:0]};
  endfunction

  always @(negedge clk) begin
    if (dut.add_valid) n_adds++;
    if (dut.cnt_q > QD) q_over++;
  end

  task automatic run_reduction(input int len, input int gap_pct, input bit poke_start);
    int idx, cyc, post;
    bit acc_prev;
    done_cnt = 0; done_cyc = -1; ready_hi = 0; throttled = 0; overrun = 0;
    @(negedge clk);
    start = 1'b1;
    len_i = LW'(len);
    @(negedge clk);
    start = 1'b0;
    len_i = '0;
    idx = 0; cyc = 1; post = 0; acc_prev = 1'b0;
    while ((cyc < 3000) && (post < 4)) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (exp_q.size() > 0) check_val("sum", {32'h0, sum}, {32'h0, exp_q.pop_front()});
      end
      if (ready) ready_hi++;
      if (ready && (idx >= len)) overrun++;
      if (!ready && busy && (idx < len)) throttled++;
      if (done_cnt > 0) post++;
      if (poke_start && (cyc == 3)) begin
        start = 1'b1;
        len_i = LW'(5);
      end else begin
        start = 1'b0;
        len_i = '0;
      end
      if (!(valid && !acc_prev)) valid = (idx < len) && (int'($urandom_range(99, 0)) >= gap_pct);
      data = (idx < len) ? elem_q[idx] : DW'($urandom());
      acc_prev = valid && ready;
      if (acc_prev) idx++;
      @(negedge clk);
      cyc++;
    end
    valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int len, v, acc, adds0;
    rst_n = 1'b0; start = 1'b0; len_i = '0; data = '0; valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",  {63'h0, busy},  64'h0);
    check_val("rst_ready", {63'h0, ready}, 64'h0);
    check_val("rst_done",  {63'h0, done},  64'h0);
    check_val("rst_sum",   {32'h0, sum},   64'h0);
    rst_n = 1'b1;

    // Four ones back to back, with a stray start pulse mid-run.
    elem_q = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    exp_q.push_back(32'h40800000);
    run_reduction(4, 0, 1'b1);
    check_val("len4_done_cnt", 64'(done_cnt), 64'd1);
    check_val("len4_overrun", 64'(overrun), 64'd0);

    elem_q.delete();
    exp_q.push_back(32'h00000000);
    run_reduction(0, 0, 1'b0);
    check_val("len0_ready_hi", 64'(ready_hi), 64'd0);
    check_val("len0_done_cnt", 64'(done_cnt), 64'd1);
    check_val("len0_done_lat", 64'(done_cyc), 64'd3);

    elem_q = {32'hC0400000};
    exp_q.push_back(32'hC0400000);
    adds0 = n_adds;
    run_reduction(1, 0, 1'b0);
    check_val("len1_adds", 64'(n_adds - adds0), 64'd0);
    check_val("len1_done_cnt", 64'(done_cnt), 64'd1);

    elem_q.delete();
    for (int i = 0; i < 64; i++) elem_q.push_back(32'h3F800000);
    exp_q.push_back(32'h42800000);
    run_reduction(64, 30, 1'b0);
    check_val("len64gap_done_cnt", 64'(done_cnt), 64'd1);
    check_val("len64gap_qbound", 64'(q_over), 64'd0);
    check_val("len64gap_overrun", 64'(overrun), 64'd0);

    exp_q.push_back(32'h42800000);
    run_reduction(64, 0, 1'b0);
    check_val("len64_done_cnt", 64'(done_cnt), 64'd1);
    check_val("len64_throttle", 64'(throttled > 0), 64'd1);

    elem_q = {32'h7F800000, 32'h3F800000, 32'hFF800000};
    exp_q.push_back(32'h7FC00000);
    run_reduction(3, 0, 1'b0);
    check_val("inf_done_cnt", 64'(done_cnt), 64'd1);

    // Reset in the middle of a long run, then a fresh short run.
    @(negedge clk);
    start = 1'b1; len_i = LW'(32);
    @(negedge clk);
    start = 1'b0; len_i = '0;
    valid = 1'b1; data = 32'h3F800000;
    repeat (12) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_busy",  {63'h0, busy},  64'h0);
    check_val("midrst_ready", {63'h0, ready}, 64'h0);
    check_val("midrst_sum",   {32'h0, sum},   64'h0);
    elem_q = {32'h40000000, 32'h40000000};
    exp_q.push_back(32'h40800000);
    run_reduction(2, 0, 1'b0);
    check_val("midrst_done_cnt", 64'(done_cnt), 64'd1);

    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(40, 0));
      acc = 0;
      elem_q.delete();
      for (int i = 0; i < len; i++) begin
        v = int'($urandom_range(16, 0)) - 8;
        acc += v;
        elem_q.push_back(int2fp(v));
      end
      exp_q.push_back(int2fp(acc));
      run_reduction(len, int'($urandom_range(50, 0)), 1'b0);
      check_val("rand_done_cnt", 64'(done_cnt), 64'd1);
      check_val("rand_overrun", 64'(overrun), 64'd0);
    end
    check_val("final_qbound", 64'(q_over), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
